// File: rtl/core_seq_ctrl.sv
// Weight-stationary pass sequencer driving corelet instruction word, xmem reads and pmem writes.
// Latency: outputs registered; first xmem read appears the cycle after the accepted start.
// Backpressure: DRAIN stalls while ofifo_valid is low; no other phase waits on inputs.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            one-cycle pulse, accepted only in IDLE
//   ofifo_valid      corelet ofifo holds an output row
//   inst             corelet instruction ([0] kload, [1] exec, [4] L0 rd, [5] L0 wr, [6] ofifo rd)
//   xmem_rd/_addr    activation/weight SRAM read strobe and address
//   pmem_wr/_addr    psum SRAM write strobe and address
//   busy, done       pass in flight / one-cycle completion pulse
module core_seq_ctrl #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int xaddr_bw = 11,
    parameter int paddr_bw = 11,
    parameter int w_base   = 0,
    parameter int x_base   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ofifo_valid,
    output logic [33:0]         inst,
    output logic                xmem_rd,
    output logic [xaddr_bw-1:0] xmem_addr,
    output logic                pmem_wr,
    output logic [paddr_bw-1:0] pmem_addr,
    output logic                busy,
    output logic                done
);

    localparam int TMAX = (row > col) ? ((row > len_nij) ? row : len_nij)
                                      : ((col > len_nij) ? col : len_nij);
    localparam int TW = $clog2(TMAX + 1);
    localparam int KW = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int NW = $clog2(len_nij + 1);

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_ROW    = TW'(row);
    localparam logic [TW-1:0] T_ROW_M1 = TW'(row - 1);
    localparam logic [TW-1:0] T_COL_M1 = TW'(col - 1);
    localparam logic [TW-1:0] T_NIJ    = TW'(len_nij);
    localparam logic [TW-1:0] T_NIJ_M1 = TW'(len_nij - 1);
    localparam logic [KW-1:0] K_ONE    = KW'(1);
    localparam logic [KW-1:0] K_LAST   = KW'(len_kij - 1);
    localparam logic [NW-1:0] N_ONE    = NW'(1);
    localparam logic [NW-1:0] N_ALL    = NW'(len_nij);

    typedef enum logic [3:0] {
        IDLE, W_WR, K_LD, K_WAIT, X_WR, EXEC, DRAIN, NEXT, FIN
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         t_q, t_d;       // cycle index within the current phase
    logic [KW-1:0]         kij_q, kij_d;
    logic [NW-1:0]         rd_q, rd_d;     // ofifo reads issued in this DRAIN
    logic [NW-1:0]         wr_q, wr_d;     // pmem writes issued in this DRAIN
    logic [33:0]           inst_q, inst_d;
    logic                  xmem_rd_q, xmem_rd_d;
    logic [xaddr_bw-1:0]   xmem_addr_q, xmem_addr_d;
    logic                  pmem_wr_q, pmem_wr_d;
    logic [paddr_bw-1:0]   pmem_addr_q, pmem_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        kij_d       = kij_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        inst_d      = '0;
        xmem_rd_d   = 1'b0;
        xmem_addr_d = '0;
        pmem_wr_d   = 1'b0;
        pmem_addr_d = '0;

        // Next state; DRAIN strobes are decided here because they depend on
        // the current ofifo_valid and on the read visible this cycle.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = W_WR;
                    t_d     = '0;
                    kij_d   = '0;
                end
            end
            W_WR: begin
                if (t_q == T_ROW) begin
                    state_d = K_LD;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            K_LD: begin
                if (t_q == T_ROW_M1) begin
                    state_d = K_WAIT;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            K_WAIT: begin
                if (t_q == T_COL_M1) begin
                    state_d = X_WR;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            X_WR: begin
                if (t_q == T_NIJ) begin
                    state_d = EXEC;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            EXEC: begin
                if (t_q == T_NIJ_M1) begin
                    state_d = DRAIN;
                    t_d     = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                    // First DRAIN cycle can already read the ofifo.
                    if (ofifo_valid) begin
                        inst_d[6] = 1'b1;
                        rd_d      = N_ONE;
                    end
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            DRAIN: begin
                if (ofifo_valid && (rd_q != N_ALL)) begin
                    inst_d[6] = 1'b1;
                    rd_d      = rd_q + N_ONE;
                end
                // A read visible now lands in pmem next cycle.
                if (inst_q[6]) begin
                    pmem_wr_d   = 1'b1;
                    pmem_addr_d = paddr_bw'(int'(kij_q) * len_nij + int'(wr_q));
                    wr_d        = wr_q + N_ONE;
                end
                // Final write is on the bus this cycle: leave after it.
                if (pmem_wr_q && (wr_q == N_ALL)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (kij_q == K_LAST) begin
                    state_d = FIN;
                end else begin
                    kij_d   = kij_q + K_ONE;
                    state_d = W_WR;
                    t_d     = '0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Phase strobes for the cycle that state_d will occupy. The L0 write
        // trails the SRAM read by one cycle, hence the extra t=row / t=len_nij slot.
        case (state_d)
            W_WR: begin
                if (t_d != T_ROW) begin
                    xmem_rd_d   = 1'b1;
                    xmem_addr_d = xaddr_bw'(w_base + int'(kij_d) * row + int'(t_d));
                end
                if (t_d != '0) inst_d[5] = 1'b1;
            end
            K_LD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
            end
            X_WR: begin
                if (t_d != T_NIJ) begin
                    xmem_rd_d   = 1'b1;
                    xmem_addr_d = xaddr_bw'(x_base + int'(t_d));
                end
                if (t_d != '0) inst_d[5] = 1'b1;
            end
            EXEC: begin
                inst_d[4] = 1'b1;
                inst_d[1] = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE) && (state_d != FIN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            kij_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            inst_q      <= '0;
            xmem_rd_q   <= 1'b0;
            xmem_addr_q <= '0;
            pmem_wr_q   <= 1'b0;
            pmem_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            kij_q       <= kij_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            inst_q      <= inst_d;
            xmem_rd_q   <= xmem_rd_d;
            xmem_addr_q <= xmem_addr_d;
            pmem_wr_q   <= pmem_wr_d;
            pmem_addr_q <= pmem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst      = inst_q;
    assign xmem_rd   = xmem_rd_q;
    assign xmem_addr = xmem_addr_q;
    assign pmem_wr   = pmem_wr_q;
    assign pmem_addr = pmem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;

    logic [33:0] d1_inst, d3_inst;
    logic        d1_xrd, d3_xrd, d1_pwr, d3_pwr, d1_busy, d3_busy, d1_done, d3_done;
    logic [10:0] d1_xa, d3_xa, d1_pa, d3_pa;

    always #5 clk = ~clk;

    // Single-kij pass and three-kij pass share every input.
    core_seq_ctrl #(.row(2), .col(2), .len_kij(1), .len_nij(4)) dut1 (
        .clk(clk), .reset(rst_n), .start(start), .ofifo_valid(valid),
        .inst(d1_inst), .xmem_rd(d1_xrd), .xmem_addr(d1_xa),
        .pmem_wr(d1_pwr), .pmem_addr(d1_pa), .busy(d1_busy), .done(d1_done));

    core_seq_ctrl #(.row(2), .col(2), .len_kij(3), .len_nij(4)) dut3 (
        .clk(clk), .reset(rst_n), .start(start), .ofifo_valid(valid),
        .inst(d3_inst), .xmem_rd(d3_xrd), .xmem_addr(d3_xa),
        .pmem_wr(d3_pwr), .pmem_addr(d3_pa), .busy(d3_busy), .done(d3_done));

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        valid;
        logic [33:0] inst;
        logic        xrd;
        logic [10:0] xa;
        logic        pwr;
        logic [10:0] pa;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   excl_bad = 0;
    logic rec3 = 1'b1;
    int   xq[$];
    int   pq[$];
    int   d3_cnt = 0;
    int   d3_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic v, input logic [33:0] i,
                       input logic xr, input int xa, input logic pw, input int pa,
                       input logic b, input logic d);
        vec_t e;
        e.rst_n = r; e.start = s; e.valid = v; e.inst = i;
        e.xrd = xr; e.xa = 11'(xa); e.pwr = pw; e.pa = 11'(pa);
        e.busy = b; e.done = d;
        tbl.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (d1_inst[4] && d1_inst[5]) excl_bad++;
        if (d3_inst[4] && d3_inst[5]) excl_bad++;
        if (rec3) begin
            if (d3_xrd) xq.push_back(int'(d3_xa));
            if (d3_pwr) pq.push_back(int'(d3_pa));
            if (d3_done) begin
                d3_cnt++;
                d3_cyc = cyc;
            end
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int t0;
        int exq[$];
        t0 = -1;

        // reset held with start toggling, then idle after release
        add(0,1,0, 34'h0,  0,0,    0,0, 0,0);
        add(0,0,1, 34'h0,  0,0,    0,0, 0,0);
        add(0,1,1, 34'h0,  0,0,    0,0, 0,0);
        add(0,1,0, 34'h0,  0,0,    0,0, 0,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 0,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 0,0);
        // pass: W_WR x3, K_LD x2, K_WAIT x2, X_WR x5, EXEC x4, DRAIN x5, NEXT, FIN
        add(1,1,1, 34'h0,  1,0,    0,0, 1,0);
        add(1,0,1, 34'h20, 1,1,    0,0, 1,0);
        add(1,0,1, 34'h20, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h11, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h11, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 1,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 1,0);
        add(1,0,1, 34'h0,  1,1024, 0,0, 1,0);
        add(1,0,1, 34'h20, 1,1025, 0,0, 1,0);
        add(1,0,1, 34'h20, 1,1026, 0,0, 1,0);
        add(1,1,1, 34'h20, 1,1027, 0,0, 1,0); // start while busy: ignored
        add(1,0,1, 34'h20, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h12, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h12, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h12, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h12, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h40, 0,0,    0,0, 1,0);
        add(1,0,1, 34'h40, 0,0,    1,0, 1,0);
        add(1,0,1, 34'h40, 0,0,    1,1, 1,0);
        add(1,0,1, 34'h40, 0,0,    1,2, 1,0);
        add(1,0,1, 34'h0,  0,0,    1,3, 1,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 1,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 0,1);
        add(1,0,1, 34'h0,  0,0,    0,0, 0,0);
        add(1,0,1, 34'h0,  0,0,    0,0, 0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            start = tbl[i].start;
            valid = tbl[i].valid;
            step();
            if (t0 < 0 && tbl[i].rst_n && tbl[i].start) t0 = cyc;
            chk($sformatf("vec%0d", i),
                64'({d1_inst, d1_xrd, d1_xa, d1_pwr, d1_pa, d1_busy, d1_done}),
                64'({tbl[i].inst, tbl[i].xrd, tbl[i].xa, tbl[i].pwr, tbl[i].pa,
                     tbl[i].busy, tbl[i].done}));
        end
        start = 1'b0;

        // three-kij pass, observed over the same run
        for (int g = 0; g < 100 && d3_cnt == 0; g++) step();
        for (int g = 0; g < 3; g++) step();
        rec3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exq.push_back(2 * k);
            exq.push_back(2 * k + 1);
            for (int j = 0; j < 4; j++) exq.push_back(1024 + j);
        end
        chk("kij3 xmem reads", 64'(xq.size()), 64'(exq.size()));
        for (int i = 0; i < xq.size() && i < exq.size(); i++)
            chk($sformatf("kij3 xaddr%0d", i), 64'(xq[i]), 64'(exq[i]));
        chk("kij3 pmem writes", 64'(pq.size()), 64'(12));
        for (int i = 0; i < pq.size() && i < 12; i++)
            chk($sformatf("kij3 paddr%0d", i), 64'(pq[i]), 64'(i));
        chk("kij3 done pulses", 64'(d3_cnt), 64'(1));
        chk("kij3 done cycle", 64'(d3_cyc - t0), 64'(66));

        // second pass after done
        begin
            int ts, td, pw;
            td = -1;
            pw = 0;
            start = 1'b1;
            step();
            ts = cyc;
            start = 1'b0;
            for (int g = 0; g < 60 && td < 0; g++) begin
                step();
                if (d1_pwr) pw++;
                if (d1_done) td = cyc;
            end
            chk("restart done offset", 64'(td - ts), 64'(22));
            chk("restart pmem writes", 64'(pw), 64'(4));
        end

        // drain stall: ofifo_valid 1,0,0,1,0,0,...
        begin
            int i6, pw, stall_bad, gap_bad, seen;
            logic pv, prev_i6;
            i6 = 0; pw = 0; stall_bad = 0; gap_bad = 0; seen = 0;
            prev_i6 = 1'b0;
            do_reset();
            start = 1'b1;
            valid = 1'b0;
            step();
            start = 1'b0;
            for (int c = 0; c < 300 && seen == 0; c++) begin
                valid = (c % 3 == 0);
                pv = valid;
                step();
                // registered response: a read follows a cycle with valid high
                if (d1_inst[6]) begin
                    i6++;
                    if (!pv) stall_bad++;
                end
                if (d1_pwr) begin
                    if (!prev_i6) stall_bad++;
                    if (d1_pa != 11'(pw)) gap_bad++;
                    pw++;
                end
                prev_i6 = d1_inst[6];
                if (d1_done) seen = 1;
            end
            chk("stall ofifo reads", 64'(i6), 64'(4));
            chk("stall pmem writes", 64'(pw), 64'(4));
            chk("stall strobe order", 64'(stall_bad), 64'(0));
            chk("stall addr gaps", 64'(gap_bad), 64'(0));
            chk("stall done seen", 64'(seen), 64'(1));
        end

        // reset dropped in EXEC
        begin
            int found, nz;
            found = 0;
            nz = 0;
            do_reset();
            valid = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            for (int g = 0; g < 40 && found == 0; g++) begin
                step();
                if (d1_inst == 34'h12) found = 1;
            end
            chk("reached EXEC", 64'(found), 64'(1));
            #3;
            rst_n = 1'b0;
            #1;
            chk("async clear dut1",
                64'({d1_inst, d1_xrd, d1_xa, d1_pwr, d1_pa, d1_busy, d1_done}), 64'(0));
            chk("async clear dut3",
                64'({d3_inst, d3_xrd, d3_xa, d3_pwr, d3_pa, d3_busy, d3_done}), 64'(0));
            step();
            step();
            rst_n = 1'b1;
            for (int g = 0; g < 5; g++) begin
                step();
                if ({d1_inst, d1_xrd, d1_xa, d1_pwr, d1_pa, d1_busy, d1_done} != '0) nz++;
            end
            chk("idle after release", 64'(nz), 64'(0));
            start = 1'b1;
            step();
            start = 1'b0;
            chk("fresh start", 64'({d1_xrd, d1_xa, d1_busy}), 64'({1'b1, 11'd0, 1'b1}));
            step();
        end

        chk("inst4_5 exclusive", 64'(excl_bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Sequencer directly upstream of the corelet; generates its 34-bit instruction word plus activation/weight SRAM (xmem) read strobes and psum SRAM (pmem) write strobes.
- Runs one weight-stationary convolution pass: for each kernel index kij it loads weights, shifts them into the MAC array, streams activations and drains the ofifo into pmem.
- Driven by a single start pulse; reports completion with a done pulse.

Parameters:
- row, 8, MAC array rows (weight words per kij)
- col, 8, MAC array columns (weight propagation wait cycles)
- len_kij, 9, kernel positions per pass
- len_nij, 36, output pixels per kij
- xaddr_bw, 11, xmem address width
- paddr_bw, 11, pmem address width
- w_base, 0, xmem base address of weights, kij-major (kij*row + r)
- x_base, 1024, xmem base address of activations

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a pass when idle
- ofifo_valid  input  1  corelet ofifo holds a full output row
- inst  output  34  corelet instruction: [0] kernel load, [1] execute, [4] L0 rd, [5] L0 wr, [6] ofifo rd, [33] sfp acc; all other bits 0
- xmem_rd  output  1  xmem read enable (data valid next cycle)
- xmem_addr  output  xaddr_bw  xmem read address
- pmem_wr  output  1  pmem write enable
- pmem_addr  output  paddr_bw  pmem write address
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. While reset is low: state=IDLE, every counter 0, all outputs 0. Reset asserted mid-pass aborts immediately; no partial pulses after release.
- States: IDLE, W_WR, K_LD, K_WAIT, X_WR, EXEC, DRAIN, NEXT, FIN.
- IDLE: start=1 -> W_WR with kij=0, busy=1. Otherwise start is ignored; start while busy has no effect.
- W_WR: row+1 cycles, t=0..row. xmem_rd=1 and xmem_addr=w_base+kij*row+t for t<row. inst[5]=1 for t>=1, covering the 1-cycle SRAM latency.
- K_LD: row cycles with inst[4]=1 and inst[0]=1.
- K_WAIT: col cycles, inst=0.
- X_WR: len_nij+1 cycles. Same pattern as W_WR with addr=x_base+t (t<len_nij); inst[5]=1 for t>=1.
- EXEC: len_nij cycles with inst[4]=1 and inst[1]=1.
- DRAIN:
  - inst[6]=1 in any cycle where ofifo_valid=1 and reads<len_nij; each such cycle counts one read.
  - ofifo_valid=0 stalls with inst[6]=0 and no timeout.
  - pmem_wr asserts exactly one cycle after each ofifo read, with pmem_addr=kij*len_nij+n, where n is that read's index, 0-based.
  - Leave DRAIN in the cycle after the final pmem_wr.
- NEXT: 1 cycle. kij<len_kij-1 -> kij++, W_WR. Otherwise -> FIN.
- FIN: done=1 and busy=0 for one cycle; inst[33] stays 0 for the whole pass (sfp acc is a separate phase); -> IDLE.
- Counter widths are sized by $clog2 of their max+1. Address arithmetic truncates to the address width, so wrap-around is silent; parameters must keep ranges in bounds.
- Exactly one of W_WR, X_WR, or the DRAIN write uses each memory port in a cycle; inst[4] and inst[5] are never both 1.

Test Plan:
- Reset/idle: hold reset=0 with random start, then release -> inst=0, xmem_rd=0, pmem_wr=0, busy=0, done=0 until the first start.
- Single pass, row=col=2, len_kij=1, len_nij=4, ofifo_valid tied 1:
  - xmem_addr 0,1 then 1024..1027.
  - inst[0]&[4] high for 2 cycles; inst[1]&[4] high for 4 cycles.
  - pmem_wr at addr 0..3.
  - done exactly 1 cycle, 3+2+2+5+4+5+1 = 22 cycles after the start cycle.
- Multi-kij, len_kij=3: weight addresses restart at kij*row each iteration (0,1 / 2,3 / 4,5); pmem_addr runs continuously 0..11; a single done pulse.
- Drain stall: ofifo_valid toggles 1,0,0,1,... -> inst[6] asserts only when valid; pmem_wr count equals len_nij; addresses stay contiguous with no gaps.
- Start during busy plus a second start after done: the mid-pass start is ignored (no restart, same done timing); the post-done start runs a full second pass.
- Mid-pass reset: drop reset during EXEC -> all outputs 0 asynchronously (same cycle); after release the FSM stays in IDLE until a new start.
